prog_sequencer: RTL and testbench

PROG_SEQUENCER -- requirements
Module: prog_sequencer

---
 rtl/prog_sequencer.sv | 138 +++++++++++++
 tb/tb_prog_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// Program sequencer: buffers up to 16 CPU instruction words and plays them out
// on consecutive cycles, or one per step pulse when step_mode is set.
module prog_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  input  logic       wr_sel,
  output logic       wr_ready,
  input  logic       start,
  input  logic       step,
  input  logic       clear,
  input  logic       step_mode,
  output logic [7:0] instr,
  output logic       cpu_sel,
  output logic       instr_valid,
  output logic [3:0] pc,
  output logic [4:0] count,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StPause = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [4:0] wp_q, wp_d;
  logic [3:0] rp_q, rp_d;
  // Set when the most recently issued word was the final one of the program.
  logic       last_q, last_d;
  logic [7:0] instr_q, instr_d;
  logic       sel_q, sel_d;
  logic       valid_q, valid_d;
  logic [3:0] pc_q, pc_d;

  logic [8:0] mem [16];

  logic       wr_fire;
  logic [4:0] count_post;
  logic       last_issue;

  assign wr_ready   = (state_q == StIdle) && !wp_q[4];
  assign wr_fire    = ena && wr_valid && wr_ready && !clear;
  assign count_post = wp_q + {4'd0, wr_fire};
  assign last_issue = ({1'b0, rp_q} == (wp_q - 5'd1));

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    last_d  = last_q;
    instr_d = 8'h00;
    sel_d   = 1'b0;
    valid_d = 1'b0;
    pc_d    = pc_q;
    if (clear) begin
      state_d = StIdle;
      wp_d    = 5'd0;
      rp_d    = 4'd0;
      last_d  = 1'b0;
      pc_d    = 4'd0;
    end else begin
      if (wr_fire) begin
        wp_d = wp_q + 5'd1;
      end
      case (state_q)
        StIdle, StDone: begin
          if (start && (count_post != 5'd0)) begin
            state_d = StRun;
            rp_d    = 4'd0;
            last_d  = 1'b0;
          end
        end
        StRun: begin
          instr_d = mem[rp_q][7:0];
          sel_d   = mem[rp_q][8];
          valid_d = 1'b1;
          pc_d    = rp_q;
          rp_d    = rp_q + 4'd1;
          last_d  = last_issue;
          // In step mode even the final word parks in PAUSE; the next step ends the run.
          if (step_mode) begin
            state_d = StPause;
          end else if (last_issue) begin
            state_d = StDone;
          end
        end
        StPause: begin
          if (step) begin
            state_d = last_q ? StDone : StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wp_q    <= 5'd0;
      rp_q    <= 4'd0;
      last_q  <= 1'b0;
      instr_q <= 8'h00;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      pc_q    <= 4'd0;
    end else if (ena) begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      last_q  <= last_d;
      instr_q <= instr_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
    end
  end

  // Buffer storage carries no reset; only the write pointer defines valid contents.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wp_q[3:0]] <= {wr_sel, wr_data};
    end
  end

  assign instr       = instr_q;
  assign cpu_sel     = sel_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign count       = wp_q;
  assign busy        = (state_q == StRun) || (state_q == StPause);
  assign done        = (state_q == StDone);

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer; expected streams come from a queue model
// of the loaded program.
module tb_prog_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, ena, wr_valid, wr_sel, start, step, clear, step_mode;
  logic [7:0] wr_data;
  logic       wr_ready, cpu_sel, instr_valid, busy, done;
  logic [7:0] instr;
  logic [3:0] pc;
  logic [4:0] count;

  int total = 0;
  int bad   = 0;
  logic [8:0] prog [$];

  always #5 clk = ~clk;

  prog_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_sel     (wr_sel),
    .wr_ready   (wr_ready),
    .start      (start),
    .step       (step),
    .clear      (clear),
    .step_mode  (step_mode),
    .instr      (instr),
    .cpu_sel    (cpu_sel),
    .instr_valid(instr_valid),
    .pc         (pc),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    prog.delete();
  endtask

  task automatic load(input logic [8:0] w);
    wr_valid = 1'b1;
    wr_data  = w[7:0];
    wr_sel   = w[8];
    tick();
    wr_valid = 1'b0;
    if (prog.size() < 16) prog.push_back(w);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    total++;
    if ({instr, cpu_sel, instr_valid, pc} !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h/%b/%b/%h exp=00/0/0/0", instr, cpu_sel, instr_valid, pc);
    end
    total++;
    if ({count, busy, done, wr_ready} !== 8'b0000_0001) begin
      bad++;
      $display("FAIL reset_status got count=%0d busy=%b done=%b rdy=%b exp 0/0/0/1",
               count, busy, done, wr_ready);
    end
  endtask

  task automatic test_basic;
    do_clear();
    load({1'b0, 8'h21}); load({1'b0, 8'h31}); load({1'b0, 8'h42}); load({1'b0, 8'h52});
    load({1'b1, 8'h21});
    pulse_start();
    total++;
    if ({busy, instr_valid} !== 2'b10) begin
      bad++;
      $display("FAIL basic_latency got busy=%b valid=%b exp 1/0", busy, instr_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({instr_valid, cpu_sel, instr, pc} !== {1'b1, prog[i], 4'(i)}) begin
        bad++;
        $display("FAIL basic_word%0d got v=%b sel=%b instr=%h pc=%0d exp 1/%b/%h/%0d", i,
                 instr_valid, cpu_sel, instr, pc, prog[i][8], prog[i][7:0], i);
      end
    end
    tick();
    total++;
    if ({done, busy, instr_valid, instr} !== {3'b100, 8'h00}) begin
      bad++;
      $display("FAIL basic_done got done=%b busy=%b v=%b instr=%h exp 1/0/0/00",
               done, busy, instr_valid, instr);
    end
  endtask

  task automatic test_full;
    do_clear();
    for (int i = 0; i < 16; i++) load(9'($urandom));
    total++;
    if ({count, wr_ready} !== {5'd16, 1'b0}) begin
      bad++;
      $display("FAIL full_count got count=%0d rdy=%b exp 16/0", count, wr_ready);
    end
    load(~prog[0]);
    total++;
    if (count !== 5'd16) begin
      bad++;
      $display("FAIL full_refuse got count=%0d exp 16", count);
    end
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      tick();
      total++;
      if ({instr_valid, cpu_sel, instr, pc} !== {1'b1, prog[i], 4'(i)}) begin
        bad++;
        $display("FAIL full_word%0d got v=%b word=%h pc=%0d exp 1/%h/%0d", i,
                 instr_valid, {cpu_sel, instr}, pc, prog[i], i);
      end
    end
    tick();
    total++;
    if ({done, instr_valid} !== 2'b10) begin
      bad++;
      $display("FAIL full_done got done=%b v=%b exp 1/0", done, instr_valid);
    end
  endtask

  task automatic test_step;
    int cnt;
    do_clear();
    for (int i = 0; i < 3; i++) load(9'($urandom));
    step_mode = 1'b1;
    pulse_start();
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (instr_valid) begin
        cnt++;
        total++;
        if ({cpu_sel, instr} !== prog[0]) begin
          bad++;
          $display("FAIL step_word0 got %h exp %h", {cpu_sel, instr}, prog[0]);
        end
      end
    end
    total++;
    if ({cnt[3:0], busy} !== {4'd1, 1'b1}) begin
      bad++;
      $display("FAIL step_first got words=%0d busy=%b exp 1/1", cnt, busy);
    end
    for (int p = 1; p <= 3; p++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      if (p == 3) begin
        total++;
        if ({done, instr_valid} !== 2'b10) begin
          bad++;
          $display("FAIL step_done got done=%b v=%b exp 1/0", done, instr_valid);
        end
      end else begin
        cnt = instr_valid ? 1 : 0;
        for (int c = 0; c < 3; c++) begin
          tick();
          if (instr_valid) begin
            cnt++;
            total++;
            if ({cpu_sel, instr, pc} !== {prog[p], 4'(p)}) begin
              bad++;
              $display("FAIL step_word%0d got %h pc=%0d exp %h pc=%0d", p, {cpu_sel, instr},
                       pc, prog[p], p);
            end
          end
        end
        total++;
        if (cnt != 1) begin
          bad++;
          $display("FAIL step_pulse%0d got words=%0d exp 1", p, cnt);
        end
      end
    end
    step_mode = 1'b0;
  endtask

  task automatic test_empty_and_clear;
    do_clear();
    pulse_start();
    tick();
    total++;
    if ({busy, done, instr_valid} !== 3'b000) begin
      bad++;
      $display("FAIL empty_start got busy=%b done=%b v=%b exp 0/0/0", busy, done, instr_valid);
    end
    for (int i = 0; i < 3; i++) load(9'($urandom));
    pulse_start();
    tick();
    tick();
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    prog.delete();
    total++;
    if ({busy, done, instr_valid, instr, count, wr_ready} !== {3'b000, 8'h00, 5'd0, 1'b1}) begin
      bad++;
      $display("FAIL clear_start got busy=%b done=%b v=%b instr=%h count=%0d rdy=%b",
               busy, done, instr_valid, instr, count, wr_ready);
    end
  endtask

  task automatic test_freeze_replay;
    do_clear();
    for (int i = 0; i < 5; i++) load(9'($urandom));
    pulse_start();
    tick();
    tick();
    ena = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({instr_valid, cpu_sel, instr, pc} !== {1'b1, prog[1], 4'd1}) begin
        bad++;
        $display("FAIL freeze_hold%0d got v=%b word=%h pc=%0d exp 1/%h/1", c, instr_valid,
                 {cpu_sel, instr}, pc, prog[1]);
      end
    end
    ena = 1'b1;
    for (int i = 2; i < 5; i++) begin
      tick();
      total++;
      if ({instr_valid, cpu_sel, instr, pc} !== {1'b1, prog[i], 4'(i)}) begin
        bad++;
        $display("FAIL freeze_resume%0d got word=%h pc=%0d exp %h/%0d", i, {cpu_sel, instr},
                 pc, prog[i], i);
      end
    end
    tick();
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({instr_valid, cpu_sel, instr, pc} !== {1'b1, prog[i], 4'(i)}) begin
        bad++;
        $display("FAIL replay_word%0d got v=%b word=%h pc=%0d exp 1/%h/%0d", i, instr_valid,
                 {cpu_sel, instr}, pc, prog[i], i);
      end
    end
    tick();
    total++;
    if ({done, instr_valid} !== 2'b10) begin
      bad++;
      $display("FAIL replay_done got done=%b v=%b exp 1/0", done, instr_valid);
    end
  endtask

  task automatic test_async_reset;
    do_clear();
    for (int i = 0; i < 4; i++) load(9'($urandom) | 9'h001);
    pulse_start();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({instr, cpu_sel, instr_valid, pc, count, busy, done, wr_ready} !==
        {8'h00, 1'b0, 1'b0, 4'd0, 5'd0, 3'b001}) begin
      bad++;
      $display("FAIL async_reset got instr=%h sel=%b v=%b pc=%0d count=%0d busy=%b done=%b",
               instr, cpu_sel, instr_valid, pc, count, busy, done);
    end
    #2 rst_n = 1'b1;
    prog.delete();
    tick();
    load(9'h1a5);
    pulse_start();
    tick();
    total++;
    if ({instr_valid, cpu_sel, instr} !== {1'b1, 9'h1a5}) begin
      bad++;
      $display("FAIL after_reset got v=%b word=%h exp 1/1a5", instr_valid, {cpu_sel, instr});
    end
    tick();
  endtask

  task automatic test_random;
    int n, issued, cyc;
    for (int it = 0; it < 6; it++) begin
      do_clear();
      n = $urandom_range(1, 16);
      for (int i = 0; i < n - 1; i++) load(9'($urandom));
      // Final word is offered in the same cycle as start and must join the run.
      prog.push_back(9'($urandom));
      wr_valid = 1'b1;
      wr_data  = prog[n-1][7:0];
      wr_sel   = prog[n-1][8];
      start    = 1'b1;
      tick();
      wr_valid = 1'b0;
      start    = 1'b0;
      issued = 0;
      cyc    = 0;
      while (issued <= n && cyc < 200) begin
        ena = ($urandom_range(0, 3) != 0);
        tick();
        cyc++;
        if (ena) issued++;
        total++;
        if (issued == 0) begin
          if (instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL rand%0d_pre got v=%b exp 0", it, instr_valid);
          end
        end else if (issued <= n) begin
          if ({instr_valid, cpu_sel, instr, pc} !== {1'b1, prog[issued-1], 4'(issued - 1)}) begin
            bad++;
            $display("FAIL rand%0d_word%0d got v=%b word=%h pc=%0d exp 1/%h/%0d", it, issued - 1,
                     instr_valid, {cpu_sel, instr}, pc, prog[issued-1], issued - 1);
          end
        end else if ({done, instr_valid, instr} !== {2'b10, 8'h00}) begin
          bad++;
          $display("FAIL rand%0d_done got done=%b v=%b instr=%h exp 1/0/00", it, done,
                   instr_valid, instr);
        end
      end
      ena = 1'b1;
      if (issued <= n) begin
        total++;
        bad++;
        $display("FAIL rand%0d_timeout got issued=%0d exp %0d", it, issued, n + 1);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b1;
    wr_valid  = 1'b0;
    wr_data   = 8'h00;
    wr_sel    = 1'b0;
    start     = 1'b0;
    step      = 1'b0;
    clear     = 1'b0;
    step_mode = 1'b0;
    #12;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_full();
    test_step();
    test_empty_and_clear();
    test_freeze_replay();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
